// File: rtl/lab2_half_sub_checker_pkg.sv
// Shared types and golden model for the Lab2 half-subtractor checker.
// Optional feature macro: LAB2_CHK_STOP_ON_ERR_EN (handled in the top).
package lab2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam logic [3:0] COV_ALL = 4'hF;

  // Returns {D, B} for minuend x and subtrahend y.
  function automatic logic [1:0] half_sub_ref(
    input logic x,
    input logic y
  );
    return {x ^ y, ~x & y};
  endfunction

endpackage

// File: rtl/lab2_half_sub_ref.sv
// Combinational golden half subtractor.
// Thin wrapper around lab2_pkg::half_sub_ref.
import lab2_pkg::*;

module lab2_half_sub_ref (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign {d, b} = half_sub_ref(x, y);

endmodule

// File: rtl/lab2_half_sub_checker.sv
// Response monitor for the Lab2 half subtractor: golden compare, counters, coverage.
// Define LAB2_CHK_STOP_ON_ERR_EN to end a run on the first mismatch.
import lab2_pkg::*;

module lab2_half_sub_checker #(
  parameter int N_SAMPLES   = 4,
  parameter int CNT_W       = 8,
  parameter bit REQUIRE_COV = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_x,
  input  logic             in_y,
  input  logic             in_d,
  input  logic             in_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [3:0]       cov_mask,
  output logic [CNT_W-1:0] first_err_idx
);

  // Run length is tracked separately so a narrow CNT_W cannot cut a run short.
  localparam int RW = (CNT_W > 8) ? CNT_W : 8;
  localparam logic [RW-1:0] LAST = RW'(N_SAMPLES - 1);

  chk_state_t      state;
  logic [RW-1:0]   run_cnt;
  logic            ref_d;
  logic            ref_b;
  logic            acc;
  logic            mism;
  logic            stop;
  logic            pass_nxt;
  logic [CNT_W-1:0] err_nxt;
  logic [3:0]      cov_nxt;

  lab2_half_sub_ref u_ref (
    .x (in_x),
    .y (in_y),
    .d (ref_d),
    .b (ref_b)
  );

  assign sample_cnt = run_cnt[CNT_W-1:0];

  always_comb begin
    acc      = (state == RUN) && in_valid;
    mism     = acc && ({in_d, in_b} != {ref_d, ref_b});
    err_nxt  = err_cnt;
    cov_nxt  = cov_mask;
    if (mism && (err_cnt != '1)) err_nxt = err_cnt + 1'b1;
    if (acc) cov_nxt[{in_x, in_y}] = 1'b1;
`ifdef LAB2_CHK_STOP_ON_ERR_EN
    stop     = acc && ((run_cnt == LAST) || mism);
`else
    stop     = acc && (run_cnt == LAST);
`endif
    pass_nxt = (err_nxt == '0) &&
               (!REQUIRE_COV || (cov_nxt == COV_ALL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      run_cnt       <= '0;
      err_cnt       <= '0;
      cov_mask      <= '0;
      first_err_idx <= '1;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            run_cnt       <= '0;
            err_cnt       <= '0;
            cov_mask      <= '0;
            first_err_idx <= '1;
          end
        end
        RUN: begin
          if (acc) begin
            run_cnt  <= run_cnt + 1'b1;
            err_cnt  <= err_nxt;
            cov_mask <= cov_nxt;
            if (mism && (err_cnt == '0)) first_err_idx <= sample_cnt;
          end
          if (stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= pass_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_half_sub_checker.sv
// Directed bench for lab2_half_sub_checker: table of 4-sample runs plus
// hand sequences for gaps, start-in-run, async reset and err_cnt saturation.
module tb_lab2_half_sub_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_b = 1'b0;
  logic in_valid = 1'b0;
  logic in_x = 1'b0;
  logic in_y = 1'b0;
  logic in_d = 1'b0;
  logic in_b = 1'b0;

  logic       busy, done, pass;
  logic [7:0] err_cnt, sample_cnt, first_err_idx;
  logic [3:0] cov_mask;

  logic       busy2, done2, pass2;
  logic [1:0] err_cnt2, sample_cnt2, first_err_idx2;
  logic [3:0] cov_mask2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lab2_half_sub_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_d          (in_d),
    .in_b          (in_b),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .sample_cnt    (sample_cnt),
    .cov_mask      (cov_mask),
    .first_err_idx (first_err_idx)
  );

  lab2_half_sub_checker #(
    .N_SAMPLES (6),
    .CNT_W     (2)
  ) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_b),
    .in_valid      (in_valid),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_d          (in_d),
    .in_b          (in_b),
    .busy          (busy2),
    .done          (done2),
    .pass          (pass2),
    .err_cnt       (err_cnt2),
    .sample_cnt    (sample_cnt2),
    .cov_mask      (cov_mask2),
    .first_err_idx (first_err_idx2)
  );

  typedef struct {
    string      name;
    logic [15:0] obs;
    logic [7:0] err;
    logic [7:0] first;
    logic [7:0] scnt;
    logic [3:0] cov;
    logic       pass;
  } run_t;

  run_t runs [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] o);
    in_valid = v;
    {in_x, in_y, in_d, in_b} = o;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // obs nibbles are {x, y, d, b}, first sample in the top nibble
    runs[0] = '{"all_ok", {4'b0000, 4'b0111, 4'b1010, 4'b1100},
                8'd0, 8'hFF, 8'd4, 4'hF, 1'b1};
`ifdef LAB2_CHK_STOP_ON_ERR_EN
    runs[1] = '{"err_s2", {4'b0000, 4'b0111, 4'b1000, 4'b1100},
                8'd1, 8'd2, 8'd3, 4'h7, 1'b0};
    runs[3] = '{"err_s0", {4'b0110, 4'b0000, 4'b1010, 4'b1100},
                8'd1, 8'd0, 8'd1, 4'h2, 1'b0};
`else
    runs[1] = '{"err_s2", {4'b0000, 4'b0111, 4'b1000, 4'b1100},
                8'd1, 8'd2, 8'd4, 4'hF, 1'b0};
    runs[3] = '{"err_s0", {4'b0110, 4'b0000, 4'b1010, 4'b1100},
                8'd1, 8'd0, 8'd4, 4'hF, 1'b0};
`endif
    runs[2] = '{"no_cov", {4'b0000, 4'b0000, 4'b0000, 4'b0000},
                8'd0, 8'hFF, 8'd4, 4'h1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_scnt", sample_cnt, 0);
    chk("rst_cov", cov_mask, 0);
    chk("rst_first", first_err_idx, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      // a mismatching sample during the start edge must not be accepted
      in_valid = 1'b1;
      {in_x, in_y, in_d, in_b} = 4'b0011;
      pulse_start();
      chk({runs[r].name, "_busy0"}, busy, 1);
      chk({runs[r].name, "_scnt0"}, sample_cnt, 0);
      for (int i = 0; i < 4; i++) drive(1'b1, runs[r].obs[15 - 4*i -: 4]);
      in_valid = 1'b0;
      chk({runs[r].name, "_done"}, done, 1);
      chk({runs[r].name, "_busy"}, busy, 0);
      chk({runs[r].name, "_err"}, err_cnt, runs[r].err);
      chk({runs[r].name, "_first"}, first_err_idx, runs[r].first);
      chk({runs[r].name, "_scnt"}, sample_cnt, runs[r].scnt);
      chk({runs[r].name, "_cov"}, cov_mask, runs[r].cov);
      chk({runs[r].name, "_pass"}, pass, runs[r].pass);
      @(negedge clk);
    end

    // gapped valid, with a start pulse mid-run that must be ignored
    pulse_start();
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b1111);
    drive(1'b0, 4'b1111);
    drive(1'b1, 4'b0111);
    start = 1'b1;
    drive(1'b0, 4'b1111);
    start = 1'b0;
    chk("gap_scnt2", sample_cnt, 2);
    drive(1'b0, 4'b1111);
    drive(1'b1, 4'b1010);
    drive(1'b0, 4'b1111);
    chk("gap_scnt3", sample_cnt, 3);
    chk("gap_notdone", done, 0);
    drive(1'b1, 4'b1100);
    in_valid = 1'b0;
    chk("gap_done", done, 1);
    chk("gap_pass", pass, 1);
    chk("gap_scnt4", sample_cnt, 4);

    // async reset after two samples with an error seen
    pulse_start();
    drive(1'b1, 4'b0110);
    drive(1'b1, 4'b0111);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err_cnt, 0);
    chk("ar_scnt", sample_cnt, 0);
    chk("ar_cov", cov_mask, 0);
    chk("ar_first", first_err_idx, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) drive(1'b1, runs[0].obs[15 - 4*i -: 4]);
    in_valid = 1'b0;
    chk("ar_rerun_done", done, 1);
    chk("ar_rerun_pass", pass, 1);

    // narrow counters: every sample wrong
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 4'b0010);
    in_valid = 1'b0;
    chk("sat_done", done2, 1);
    chk("sat_first", first_err_idx2, 0);
    chk("sat_pass", pass2, 0);
`ifdef LAB2_CHK_STOP_ON_ERR_EN
    chk("sat_err", err_cnt2, 1);
    chk("sat_scnt", sample_cnt2, 1);
`else
    chk("sat_err", err_cnt2, 3);
    chk("sat_scnt", sample_cnt2, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lab2_half_sub_checker.md
# lab2_half_sub_checker

Sequential self-checking response monitor for the Lab2 half subtractor. It samples stimulus (x, y) and DUT response (D, B) on each valid cycle and compares them against a golden model. It counts mismatches and tracks coverage of the four input combinations. It sits on the observing end of the bench, opposite the stimulus driver, and reports a registered pass/fail verdict after a programmed number of samples.

## Interface
- `N_SAMPLES`, default 4: samples accepted per run; legal range 1..255.
- `CNT_W`, default 8: width of the sample and error counters.
- `REQUIRE_COV`, default 1: when 1, `pass` also requires all four (x, y) combinations to have been seen.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse; begins a run from IDLE or DONE.
- `in_valid`, in, 1: the observation on `in_x`/`in_y`/`in_d`/`in_b` is valid this cycle.
- `in_x`, `in_y`, in, 1 each: minuend and subtrahend applied to the DUT.
- `in_d`, `in_b`, in, 1 each: DUT difference and borrow.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: high while in DONE.
- `pass`, out, 1: verdict; valid only when `done` is high, otherwise 0.
- `err_cnt`, out, CNT_W: mismatching samples; saturates at all-ones.
- `sample_cnt`, out, CNT_W: samples accepted in the current run.
- `cov_mask`, out, 4: bit {x,y} is set once that combination has been accepted.
- `first_err_idx`, out, CNT_W: `sample_cnt` value of the first mismatch; all-ones if there has been none.

## Operation
- Golden model: D = x ^ y; B = ~x & y.
- A sample mismatches when `in_d` or `in_b` differs from the golden value.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on `start`.
  - RUN to DONE on the cycle the N_SAMPLES-th sample is accepted.
  - DONE to RUN on `start`.
- Entering RUN clears `sample_cnt`, `err_cnt` and `cov_mask`, and sets `first_err_idx` to all-ones.
- Accept rule: a sample is accepted when state is RUN and `in_valid` is high. `in_valid` in IDLE or DONE is ignored.
- `start` while in RUN is ignored.
- On each accepted sample:
  - `sample_cnt` increments.
  - `cov_mask[{x,y}]` sets.
  - On a mismatch, `err_cnt` increments, saturating. If this is the first mismatch, `first_err_idx` captures the pre-increment `sample_cnt`.
- `pass` = `done` & (`err_cnt` == 0) & (REQUIRE_COV ? `cov_mask` == 4'hF : 1).
- All outputs are registered.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `sample_cnt`=0, `cov_mask`=0, `first_err_idx`=all-ones.
- `start` sampled at edge k: `busy`=1 and counters cleared after edge k. The first sample can be accepted at edge k+1.
- If `start` and `in_valid` are both high at the same edge in IDLE/DONE, the sample is not accepted. Only `start` takes effect.
- Counters, `cov_mask` and `first_err_idx` reflect an accepted sample one cycle after its edge (1-cycle latency).
- The final (N_SAMPLES-th) sample is accepted at edge m. After edge m, `busy`=0, `done`=1, and `pass` is valid, with the final sample's result already included.
- Back-to-back `in_valid` every cycle is supported at full rate.
- Asserting `rst_n` low mid-run forces all reset values immediately, with no clock edge required.
- Counter overflow: `err_cnt` holds at 2^CNT_W-1.

## Configuration
- `LAB2_CHK_STOP_ON_ERR_EN` defined: the first mismatch moves RUN to DONE on that same accepting edge. `pass`=0 and `sample_cnt` shows the samples consumed.
- `LAB2_CHK_STOP_ON_ERR_EN` undefined: the run always consumes N_SAMPLES samples.

## Structure
- Package `lab2_pkg`:
  - state enum `chk_state_t` (IDLE, RUN, DONE);
  - function `half_sub_ref(x, y)` returning {D, B};
  - constant `COV_ALL` = 4'hF.
- One sub-module, `lab2_half_sub_ref`: the combinational golden model, instanced once and wrapping `half_sub_ref`.
- The FSM, counters and coverage logic all live in the top module.

## Test plan
- Correct DUT, N_SAMPLES=4, inputs 00, 01, 10, 11 at 1/cycle → `done` after 4th edge; `err_cnt`=0; `cov_mask`=F; `pass`=1; `first_err_idx`=FF.
- Sample 2 (x=1, y=0) driven with D=0 → `err_cnt`=1, `first_err_idx`=2, `pass`=0. With the macro defined: `done` after the 3rd sample, `sample_cnt`=3.
- REQUIRE_COV=1, four samples all 00 with correct responses → `err_cnt`=0, `cov_mask`=1, `pass`=0.
- `in_valid` gapped (high, low, low, high, ...) → only the high cycles are counted; `done` after the 4th accepted sample.
- `rst_n` pulled low after 2 samples → all outputs return to reset values immediately. A new `start` then runs cleanly to `pass`=1.
- CNT_W=2, N_SAMPLES=6 with all samples wrong → `err_cnt` saturates at 3; `first_err_idx`=0.
